wavegen_ctrl: RTL and testbench

Run controller for the 10-bit DAC waveform path: holds waveform configuration programmed over a valid/ready register port, sequences start, stop and burst runs, and drives `dac_data` from a phase accumulator through a selectable shaper (sawtooth, triangle, square, DC). It sits between the host/config logic and the DAC pins. It replaces free-running fixed-rate generators with a programmable step rate, amplitude scaling and finite-period bursts.

---
 rtl/wavegen_pkg.sv | 26 ++
 rtl/wavegen_if.sv | 25 ++
 rtl/wave_shaper.sv | 37 +++
 rtl/wavegen_ctrl.sv | 107 ++++++++++
 tb/tb_wavegen_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/wavegen_pkg.sv
// Shared constants and types for the DAC waveform run controller.
// Register map, waveform encodings and FSM state codes live here.
package wavegen_pkg;

    localparam int DEF_DAC_W   = 10;
    localparam int DEF_PHASE_W = 16;
    localparam int DEF_BURST_W = 16;
    localparam int CFG_AW      = 2;
    localparam int CFG_DW      = 16;

    typedef enum logic [1:0] {
        WAVE_SAW = 2'd0,
        WAVE_TRI = 2'd1,
        WAVE_SQR = 2'd2,
        WAVE_DC  = 2'd3
    } wave_e;

    localparam logic [CFG_AW-1:0] ADDR_WAVE  = 2'd0;
    localparam logic [CFG_AW-1:0] ADDR_STEP  = 2'd1;
    localparam logic [CFG_AW-1:0] ADDR_BURST = 2'd2;
    localparam logic [CFG_AW-1:0] ADDR_SCALE = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/wavegen_if.sv
// Config register write port: valid/ready with address and data.
// Host side is the master, the controller is the slave.
interface wavegen_if;
    import wavegen_pkg::*;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CFG_AW-1:0] cfg_addr;
    logic [CFG_DW-1:0] cfg_wdata;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_ready
    );

endinterface

// File: rtl/wave_shaper.sv
// Combinational shaper: maps accumulator phase to a DAC sample,
// then applies the amplitude right-shift from SCALE.
module wave_shaper
    import wavegen_pkg::*;
#(
    parameter int DAC_W   = DEF_DAC_W,
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic [PHASE_W-1:0] phase,
    input  wave_e              wave,
    input  logic [DAC_W+1:0]   scale,
    output logic [DAC_W-1:0]   sample
);

    logic [DAC_W-1:0] shape;
    logic [DAC_W-1:0] ramp;
    logic             unused_phase;

    // Triangle folds the lower half-period ramp on the phase MSB
    assign ramp = phase[PHASE_W-2 -: DAC_W];

    always_comb begin
        shape = '0;
        unique case (wave)
            WAVE_SAW: shape = phase[PHASE_W-1 -: DAC_W];
            WAVE_TRI: shape = phase[PHASE_W-1] ? ~ramp : ramp;
            WAVE_SQR: shape = phase[PHASE_W-1] ? '0 : '1;
            WAVE_DC:  shape = scale[DAC_W-1:0];
            default:  shape = '0;
        endcase
    end

    assign sample = shape >> scale[DAC_W+1:DAC_W];

    assign unused_phase = ^phase[PHASE_W-DAC_W-2:0];

endmodule

// File: rtl/wavegen_ctrl.sv
// DAC waveform run controller: config registers, IDLE/RUN sequencing,
// phase accumulator, burst period counter and registered DAC output.
module wavegen_ctrl
    import wavegen_pkg::*;
#(
    parameter int DAC_W   = DEF_DAC_W,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic             dac_clk,
    input  logic             dac_rst_n,
    wavegen_if.slave         cfg,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [DAC_W-1:0] dac_data
);

    logic [0:0]         state;
    wave_e              wave;
    logic [PHASE_W-1:0] step;
    logic [BURST_W-1:0] burst;
    logic [DAC_W+1:0]   scale;

    logic [PHASE_W-1:0] phase;
    logic [BURST_W-1:0] bcnt;
    logic [PHASE_W:0]   sum;
    logic               carry;
    logic               burst_end;
    logic               cfg_fire;
    logic [DAC_W-1:0]   sample;

    assign cfg.cfg_ready = (state == ST_IDLE);
    assign busy          = (state == ST_RUN);
    assign cfg_fire      = cfg.cfg_valid & cfg.cfg_ready;

    assign sum       = {1'b0, phase} + {1'b0, step};
    assign carry     = sum[PHASE_W];
    assign burst_end = carry && (burst != '0)
                       && (bcnt == burst - BURST_W'(1));

    wave_shaper #(
        .DAC_W   (DAC_W),
        .PHASE_W (PHASE_W)
    ) u_shaper (
        .phase  (phase),
        .wave   (wave),
        .scale  (scale),
        .sample (sample)
    );

    always_ff @(posedge dac_clk or negedge dac_rst_n) begin
        if (!dac_rst_n) begin
            wave  <= WAVE_SAW;
            step  <= '0;
            burst <= '0;
            scale <= '0;
        end else if (cfg_fire) begin
            unique case (cfg.cfg_addr)
                ADDR_WAVE:  wave  <= wave_e'(cfg.cfg_wdata[1:0]);
                ADDR_STEP:  step  <= cfg.cfg_wdata[PHASE_W-1:0];
                ADDR_BURST: burst <= cfg.cfg_wdata[BURST_W-1:0];
                ADDR_SCALE: scale <= cfg.cfg_wdata[DAC_W+1:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge dac_clk or negedge dac_rst_n) begin
        if (!dac_rst_n) begin
            state    <= ST_IDLE;
            phase    <= '0;
            bcnt     <= '0;
            done     <= 1'b0;
            dac_data <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state <= ST_RUN;
                        phase <= '0;
                        bcnt  <= '0;
                    end
                end
                ST_RUN: begin
                    phase <= sum[PHASE_W-1:0];
                    // An abort outranks a burst end on the same edge
                    if (stop) begin
                        state    <= ST_IDLE;
                        dac_data <= '0;
                    end else if (burst_end) begin
                        state    <= ST_IDLE;
                        done     <= 1'b1;
                        dac_data <= '0;
                    end else begin
                        dac_data <= sample;
                        if (carry) bcnt <= bcnt + BURST_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wavegen_ctrl.sv
// Scoreboard bench for wavegen_ctrl: expected per-cycle outputs are
// queued at stimulus time and popped against the DUT each cycle.
module tb_wavegen_ctrl;
    import wavegen_pkg::*;

    typedef struct {
        int dac;
        int bsy;
        int dn;
        int rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy;
    logic       done;
    logic [9:0] dac_data;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    wavegen_if bus ();

    wavegen_ctrl dut (
        .dac_clk   (clk),
        .dac_rst_n (rst_n),
        .cfg       (bus),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .dac_data  (dac_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int d, input int b, input int dn, input int r);
        exp_t e;
        e.dac = d;
        e.bsy = b;
        e.dn  = dn;
        e.rdy = r;
        sb.push_back(e);
    endtask

    task automatic run_check(input int n, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                chk({tag, "_underflow"}, 1, 0);
            end else begin
                e = sb.pop_front();
                chk({tag, "_dac"},  int'(dac_data),      e.dac);
                chk({tag, "_busy"}, int'(busy),          e.bsy);
                chk({tag, "_done"}, int'(done),          e.dn);
                chk({tag, "_rdy"},  int'(bus.cfg_ready), e.rdy);
            end
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        int n;
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        n = 0;
        while (!bus.cfg_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("wr_timeout", n, 0);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        #2;
        chk("rst_dac",  int'(dac_data),      0);
        chk("rst_busy", int'(busy),          0);
        chk("rst_done", int'(done),          0);
        chk("rst_rdy",  int'(bus.cfg_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Sawtooth, two-period burst
        cfg_write(ADDR_WAVE, 16'd0);
        cfg_write(ADDR_STEP, 16'h0400);
        cfg_write(ADDR_BURST, 16'd2);
        pulse_start();
        for (int k = 1; k < 128; k++) push(((k - 1) % 64) * 16, 1, 0, 0);
        push(0, 0, 1, 1);
        push(0, 0, 0, 1);
        run_check(129, "saw");

        // Triangle, continuous, aborted by stop
        cfg_write(ADDR_WAVE, 16'd1);
        cfg_write(ADDR_BURST, 16'd0);
        pulse_start();
        for (int k = 1; k <= 200; k++) begin
            int m;
            m = (k - 1) % 64;
            push((m < 32) ? m * 32 : 1023 - (m - 32) * 32, 1, 0, 0);
        end
        run_check(200, "tri");
        stop = 1'b1;
        push(0, 0, 0, 1);
        run_check(1, "tri_stop");
        stop = 1'b0;
        for (int k = 0; k < 3; k++) push(0, 0, 0, 1);
        run_check(3, "tri_idle");

        // Square at half amplitude
        cfg_write(ADDR_WAVE, 16'd2);
        cfg_write(ADDR_STEP, 16'h0800);
        cfg_write(ADDR_SCALE, 16'h0400);
        pulse_start();
        for (int k = 1; k <= 40; k++) push((((k - 1) % 32) < 16) ? 511 : 0, 1, 0, 0);
        run_check(40, "sqr");
        stop = 1'b1;
        push(0, 0, 0, 1);
        run_check(1, "sqr_stop");
        stop = 1'b0;

        // Write held during a run lands after the burst ends
        cfg_write(ADDR_WAVE, 16'd0);
        cfg_write(ADDR_SCALE, 16'd0);
        cfg_write(ADDR_STEP, 16'h1000);
        cfg_write(ADDR_BURST, 16'd1);
        pulse_start();
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = ADDR_STEP;
        bus.cfg_wdata = 16'h2000;
        for (int k = 1; k < 16; k++) push((k - 1) * 64, 1, 0, 0);
        push(0, 0, 1, 1);
        run_check(16, "stall");
        push(0, 0, 0, 1);
        run_check(1, "stall_wr");
        bus.cfg_valid = 1'b0;
        pulse_start();
        for (int k = 1; k < 8; k++) push((k - 1) * 128, 1, 0, 0);
        push(0, 0, 1, 1);
        push(0, 0, 0, 1);
        run_check(9, "newstep");

        // Stop on the final-carry edge suppresses done
        cfg_write(ADDR_WAVE, 16'd3);
        cfg_write(ADDR_SCALE, 16'd341);
        cfg_write(ADDR_STEP, 16'h8000);
        pulse_start();
        push(341, 1, 0, 0);
        run_check(1, "race_run");
        stop = 1'b1;
        push(0, 0, 0, 1);
        run_check(1, "race_stop");
        stop = 1'b0;
        push(0, 0, 0, 1);
        push(0, 0, 0, 1);
        run_check(2, "race_idle");

        // Start together with stop in IDLE is ignored
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", int'(busy), 0);
        push(0, 0, 0, 1);
        run_check(1, "ss_idle");

        // Asynchronous reset in the middle of a run
        cfg_write(ADDR_STEP, 16'h0100);
        cfg_write(ADDR_BURST, 16'd0);
        pulse_start();
        for (int k = 0; k < 3; k++) push(341, 1, 0, 0);
        run_check(3, "dc_run");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dac",  int'(dac_data),      0);
        chk("arst_busy", int'(busy),          0);
        chk("arst_done", int'(done),          0);
        chk("arst_rdy",  int'(bus.cfg_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_write(ADDR_WAVE, 16'd3);
        pulse_start();
        for (int k = 0; k < 4; k++) push(0, 1, 0, 0);
        run_check(4, "post_rst");
        stop = 1'b1;
        push(0, 0, 0, 1);
        run_check(1, "post_stop");
        stop = 1'b0;

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
